// File: rtl/zion_basic_circuit_lib_skid_buffer.sv
// Two-entry valid/ready skid buffer: a main register drives the output and a
// skid register absorbs one beat while downstream stalls. All handshake
// outputs come straight from flops.
// Optional feature: define ZION_SKID_BUF_STALL_CNT_EN to build the saturating
// upstream-stall counter; otherwise oStallCnt is tied to zero.
module zion_basic_circuit_lib_skid_buffer #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iClr,
    input  logic             iVld,
    output logic             oRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             iRdy,
    output logic [WIDTH-1:0] oDat,
    output logic [15:0]      oStallCnt
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q;
    logic             vld_q;
    logic             rdy_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    logic             xfer_in;
    logic             xfer_out;

    assign xfer_in  = iVld && rdy_q;
    assign xfer_out = vld_q && iRdy;

    assign oVld = vld_q;
    assign oRdy = rdy_q;
    assign oDat = main_q;

    // Occupancy FSM with registered valid/ready and the two data entries
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b0;
            main_q  <= INI_DATA;
            skid_q  <= INI_DATA;
        end else if (iClr) begin
            state_q <= EMPTY;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            main_q  <= INI_DATA;
            skid_q  <= INI_DATA;
        end else begin
            case (state_q)
                EMPTY: begin
                    // Ready rises here on the first edge out of reset
                    rdy_q <= 1'b1;
                    if (xfer_in) begin
                        state_q <= BUSY;
                        vld_q   <= 1'b1;
                        main_q  <= iDat;
                    end
                end
                BUSY: begin
                    if (xfer_in && xfer_out) begin
                        main_q <= iDat;
                    end else if (xfer_in) begin
                        state_q <= FULL;
                        rdy_q   <= 1'b0;
                        skid_q  <= iDat;
                    end else if (xfer_out) begin
                        state_q <= EMPTY;
                        vld_q   <= 1'b0;
                    end
                end
                FULL: begin
                    // Ready is low here, so only the output side can move
                    if (xfer_out) begin
                        state_q <= BUSY;
                        rdy_q   <= 1'b1;
                        main_q  <= skid_q;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    vld_q   <= 1'b0;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

`ifdef ZION_SKID_BUF_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Count cycles where upstream offers data but is back-pressured
    always_ff @(posedge clk) begin
        if (rst || iClr) begin
            stall_cnt_q <= '0;
        end else if (iVld && !rdy_q && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign oStallCnt = stall_cnt_q;
`else
    assign oStallCnt = CNT_W'(0);
`endif

endmodule
